// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer_if
// Purpose  : Decode/CP0 <-> fetch-sequencer signal bundle.
// Revision : 1.0  initial release
// ============================================================================
interface fetch_sequencer_if #(
    parameter int CNT_W = 8
);
    logic             stall;
    logic             jump_valid;
    logic [31:0]      pc_target;
    logic             eret;
    logic [31:0]      epc;
    logic             exc_req;
    logic [31:0]      F_PC;
    logic             D_BD;
    logic             FD_flush;
    logic             F_AdEL;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] redir_cnt;

    // Upstream side: decode next-PC calculator, hazard unit and CP0.
    modport master (
        output stall, jump_valid, pc_target, eret, epc, exc_req,
        input  F_PC, D_BD, FD_flush, F_AdEL, stall_cnt, redir_cnt
    );

    // Fetch sequencer side.
    modport slave (
        input  stall, jump_valid, pc_target, eret, epc, exc_req,
        output F_PC, D_BD, FD_flush, F_AdEL, stall_cnt, redir_cnt
    );
endinterface
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Purpose  : Fetch PC register, next-PC source select, F/D flush, delay-slot
//            bit and stall/redirect counters. Optional macro PC_ALIGN_CHECK_EN
//            enables the fetch address-error check on F_AdEL.
// Revision : 1.0  initial release
// ============================================================================
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter int          CNT_W      = 8
) (
    input  wire logic         clk,
    input  wire logic         reset,
    fetch_sequencer_if.slave  bus
);

    localparam logic [1:0] c_RUN   = 2'd0;
    localparam logic [1:0] c_HOLD  = 2'd1;
    localparam logic [1:0] c_REDIR = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic             bd_q, bd_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] redir_cnt_q, redir_cnt_d;

    logic             w_take_exc;
    logic             w_take_eret;
    logic             w_take_jump;
    logic             w_redirect;
    logic             w_flush;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= c_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_RUN: begin
                if (w_redirect)
                    state_d = c_REDIR;
                else if (bus.stall)
                    state_d = c_HOLD;
            end
            c_HOLD: begin
                if (w_redirect)
                    state_d = c_REDIR;
                else if (!bus.stall)
                    state_d = c_RUN;
            end
            c_REDIR: state_d = c_RUN;
            default: state_d = c_RUN;
        endcase
    end

    // Output decode; D holds a flushed bubble during REDIR, so its ERET/jump are void.
    always_comb begin
        w_take_exc  = bus.exc_req;
        w_take_eret = bus.eret && !bus.stall && (state_q != c_REDIR);
        w_take_jump = bus.jump_valid && !bus.stall && (state_q != c_REDIR);
        w_redirect  = w_take_exc || w_take_eret;
        w_flush     = !reset && w_redirect;
    end

    always_comb begin
        pc_d        = pc_q;
        bd_d        = bd_q;
        stall_cnt_d = stall_cnt_q;
        redir_cnt_d = redir_cnt_q;

        if (w_take_exc) begin
            pc_d = HANDLER_PC;
            bd_d = 1'b0;
        end else if (w_take_eret) begin
            pc_d = bus.epc;
            bd_d = 1'b0;
        end else if (bus.stall) begin
            pc_d = pc_q;
            bd_d = bd_q;
        end else if (w_take_jump) begin
            pc_d = bus.pc_target;
            bd_d = 1'b1;
        end else begin
            pc_d = pc_q + 32'd4;
            bd_d = 1'b0;
        end

        if (bus.stall && !w_take_exc) begin
            if (!(&stall_cnt_q))
                stall_cnt_d = stall_cnt_q + 1'b1;
        end else begin
            stall_cnt_d = '0;
        end

        if (w_redirect && !(&redir_cnt_q))
            redir_cnt_d = redir_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            bd_q        <= 1'b0;
            stall_cnt_q <= '0;
            redir_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            bd_q        <= bd_d;
            stall_cnt_q <= stall_cnt_d;
            redir_cnt_q <= redir_cnt_d;
        end
    end

    assign bus.F_PC      = pc_q;
    assign bus.D_BD      = bd_q;
    assign bus.FD_flush  = w_flush;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.redir_cnt = redir_cnt_q;

`ifdef PC_ALIGN_CHECK_EN
    // Legal fetch window is the word-aligned range 0x3000..0x6FFC.
    assign bus.F_AdEL = (pc_q[1:0] != 2'b00) ||
                        (pc_q < 32'h0000_3000) ||
                        (pc_q > 32'h0000_6FFC);
`else
    assign bus.F_AdEL = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_sequencer
// Purpose  : Directed self-checking bench for fetch_sequencer.
// Revision : 1.0  initial release
// ============================================================================
module tb_fetch_sequencer;

    localparam logic [31:0] c_RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] c_HANDLER_PC = 32'h0000_4180;
    localparam int          c_CNT_W      = 8;
    localparam int          c_CNT_MAX    = (1 << c_CNT_W) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_sequencer_if #(.CNT_W(c_CNT_W)) bus ();

    fetch_sequencer #(
        .RESET_PC   (c_RESET_PC),
        .HANDLER_PC (c_HANDLER_PC),
        .CNT_W      (c_CNT_W)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic exp_adel(input logic [31:0] pc);
`ifdef PC_ALIGN_CHECK_EN
        return (pc % 4 != 0) || (pc < 32'h3000) || (pc > 32'h6FFC);
`else
        return 1'b0;
`endif
    endfunction

    // Reference model: "bubble" means the previous edge was a redirect, so D is empty.
    logic [31:0] m_pc;
    logic        m_bd;
    int          m_sc, m_rc;
    bit          m_bubble;
    bit          m_acc_eret, m_redirect;
    bit          cmp_en = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_pc = c_RESET_PC; m_bd = 1'b0; m_sc = 0; m_rc = 0; m_bubble = 1'b0;
        end else begin
            m_acc_eret = bus.eret && !bus.stall && !m_bubble;
            m_redirect = bus.exc_req || m_acc_eret;
            if (bus.exc_req)                       begin m_pc = c_HANDLER_PC;    m_bd = 1'b0; end
            else if (m_acc_eret)                   begin m_pc = bus.epc;         m_bd = 1'b0; end
            else if (bus.stall)                    begin end
            else if (bus.jump_valid && !m_bubble)  begin m_pc = bus.pc_target;   m_bd = 1'b1; end
            else                                   begin m_pc = m_pc + 32'd4;    m_bd = 1'b0; end
            m_sc = (bus.stall && !bus.exc_req) ? ((m_sc < c_CNT_MAX) ? m_sc + 1 : c_CNT_MAX) : 0;
            if (m_redirect && m_rc < c_CNT_MAX) m_rc = m_rc + 1;
            m_bubble = m_redirect && !m_bubble;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("F_PC",      bus.F_PC, m_pc);
            chk("D_BD",      {31'b0, bus.D_BD}, {31'b0, m_bd});
            chk("FD_flush",  {31'b0, bus.FD_flush},
                {31'b0, !reset && (bus.exc_req || (bus.eret && !bus.stall && !m_bubble))});
            chk("stall_cnt", 32'(bus.stall_cnt), 32'(m_sc));
            chk("redir_cnt", 32'(bus.redir_cnt), 32'(m_rc));
            chk("F_AdEL",    {31'b0, bus.F_AdEL}, {31'b0, exp_adel(m_pc)});
        end
    end

    task automatic idle();
        bus.stall = 1'b0; bus.jump_valid = 1'b0; bus.pc_target = '0;
        bus.eret = 1'b0; bus.epc = '0; bus.exc_req = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        tick();
        bus.exc_req = 1'b1;
        #2 chk("flush_in_reset", {31'b0, bus.FD_flush}, 32'd0);
        tick();
        cmp_en = 1'b1;
        idle();
        reset = 1'b0;
        chk("rst_pc",    bus.F_PC, 32'h3000);
        chk("rst_bd",    {31'b0, bus.D_BD}, 32'd0);
        chk("rst_scnt",  32'(bus.stall_cnt), 32'd0);
        chk("rst_rcnt",  32'(bus.redir_cnt), 32'd0);

        // Sequential fetch
        tick(); chk("seq1", bus.F_PC, 32'h3004);
        tick(); chk("seq2", bus.F_PC, 32'h3008);
        tick(); chk("seq3", bus.F_PC, 32'h300C);
        chk("seq_bd", {31'b0, bus.D_BD}, 32'd0);

        // Jump with delay slot
        do_reset(); tick(); tick();
        chk("pre_jump", bus.F_PC, 32'h3008);
        bus.jump_valid = 1'b1; bus.pc_target = 32'h3100;
        tick(); chk("jump_pc", bus.F_PC, 32'h3100); chk("jump_bd", {31'b0, bus.D_BD}, 32'd1);
        idle();
        tick(); chk("after_jump_pc", bus.F_PC, 32'h3104); chk("after_jump_bd", {31'b0, bus.D_BD}, 32'd0);

        // Stall ignores jump, then releases into the jump
        do_reset(); repeat (4) tick();
        chk("pre_stall", bus.F_PC, 32'h3010);
        bus.stall = 1'b1; bus.jump_valid = 1'b1; bus.pc_target = 32'h3200;
        repeat (4) tick();
        chk("stall_pc", bus.F_PC, 32'h3010); chk("stall_cnt4", 32'(bus.stall_cnt), 32'd4);
        bus.stall = 1'b0;
        tick();
        chk("release_pc", bus.F_PC, 32'h3200); chk("release_cnt", 32'(bus.stall_cnt), 32'd0);
        chk("release_bd", {31'b0, bus.D_BD}, 32'd1);

        // Exception overrides stall; REDIR cycle ignores jump
        do_reset(); repeat (8) tick();
        chk("pre_exc", bus.F_PC, 32'h3020);
        bus.stall = 1'b1; bus.exc_req = 1'b1;
        #2 chk("exc_flush", {31'b0, bus.FD_flush}, 32'd1);
        tick(); chk("exc_pc", bus.F_PC, 32'h4180); chk("exc_rcnt", 32'(bus.redir_cnt), 32'd1);
        idle(); bus.jump_valid = 1'b1; bus.pc_target = 32'h3300;
        tick(); chk("redir_pc", bus.F_PC, 32'h4184); chk("redir_bd", {31'b0, bus.D_BD}, 32'd0);

        // Exception and ERET together, then ERET alone, then ERET under stall
        idle(); bus.eret = 1'b1; bus.exc_req = 1'b1; bus.epc = 32'h3040;
        tick(); chk("both_pc", bus.F_PC, 32'h4180); chk("both_rcnt", 32'(bus.redir_cnt), 32'd2);
        idle();
        tick(); chk("both_redir_pc", bus.F_PC, 32'h4184);
        bus.eret = 1'b1; bus.epc = 32'h3040;
        tick(); chk("eret_pc", bus.F_PC, 32'h3040); chk("eret_bd", {31'b0, bus.D_BD}, 32'd0);
        chk("eret_rcnt", 32'(bus.redir_cnt), 32'd3);
        idle(); tick();
        bus.stall = 1'b1; bus.eret = 1'b1; bus.epc = 32'h3500;
        tick(); chk("eret_stall_pc", bus.F_PC, 32'h3044); chk("eret_stall_rcnt", 32'(bus.redir_cnt), 32'd3);
        idle(); tick(); chk("eret_stall_after", bus.F_PC, 32'h3048);

        // PC+4 wraps modulo 2^32
        bus.jump_valid = 1'b1; bus.pc_target = 32'hFFFF_FFFC;
        tick(); chk("wrap_top", bus.F_PC, 32'hFFFF_FFFC);
        idle();
        tick(); chk("wrap_zero", bus.F_PC, 32'h0000_0000);

        // Stall counter saturation, then reset mid-stall
        bus.stall = 1'b1;
        repeat (c_CNT_MAX + 5) tick();
        chk("scnt_sat", 32'(bus.stall_cnt), 32'(c_CNT_MAX));
        reset = 1'b1;
        tick();
        chk("mid_rst_pc", bus.F_PC, 32'h3000); chk("mid_rst_scnt", 32'(bus.stall_cnt), 32'd0);
        chk("mid_rst_rcnt", 32'(bus.redir_cnt), 32'd0);
        reset = 1'b0; idle();

        // Fetch address error
        bus.jump_valid = 1'b1; bus.pc_target = 32'h3102;
`ifdef PC_ALIGN_CHECK_EN
        tick(); chk("adel_misalign", {31'b0, bus.F_AdEL}, 32'd1);
        bus.pc_target = 32'h7000;
        tick(); chk("adel_range", {31'b0, bus.F_AdEL}, 32'd1);
`else
        tick(); chk("adel_misalign", {31'b0, bus.F_AdEL}, 32'd0);
        bus.pc_target = 32'h7000;
        tick(); chk("adel_range", {31'b0, bus.F_AdEL}, 32'd0);
`endif
        bus.pc_target = 32'h6FFC;
        tick(); chk("adel_edge_ok", {31'b0, bus.F_AdEL}, 32'd0);
        idle(); tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
